// File: rtl/vend_ctrl_param.sv
// ---------------------------------------------------------------------------
// vend_ctrl_param
//   Parametrised vending controller. Accumulates nickel/dime/quarter credit
//   against PRICE_NK, vends one product per purchase, tracks stock, and pays
//   back change (after a vend) or a refund (on cancel) one coin per cycle in
//   which the coin dispenser signals ready.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous reset, active low
//   i_nickle       5c coin pulse
//   i_dime         10c coin pulse
//   i_quarter      25c coin pulse
//   i_cancel       refund request pulse (honoured only while collecting)
//   i_restock      reload stock to INIT_STOCK (honoured only in IDLE)
//   i_chg_ready    dispenser accepts a change coin this cycle
//   o_soda         vend pulse
//   o_chg_dime     dispense one dime this cycle
//   o_chg_nickle   dispense one nickel this cycle
//   o_coin_reject  inserted coin bounced this cycle (combinational)
//   o_credit       held credit in nickels
//   o_stock        remaining stock
//   o_sold_out     stock is zero
//   o_busy         vending or paying out
// ---------------------------------------------------------------------------
module vend_ctrl_param #(
  parameter int unsigned PRICE_NK      = 4,
  parameter int unsigned MAX_CREDIT_NK = 15,
  parameter int unsigned CREDIT_W      = 4,
  parameter int unsigned STOCK_W       = 4,
  parameter int unsigned INIT_STOCK    = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_nickle,
  input  logic                i_dime,
  input  logic                i_quarter,
  input  logic                i_cancel,
  input  logic                i_restock,
  input  logic                i_chg_ready,
  output logic                o_soda,
  output logic                o_chg_dime,
  output logic                o_chg_nickle,
  output logic                o_coin_reject,
  output logic [CREDIT_W-1:0] o_credit,
  output logic [STOCK_W-1:0]  o_stock,
  output logic                o_sold_out,
  output logic                o_busy
);

  // Headroom so credit + quarter never wraps before the range compare.
  localparam int unsigned       SUM_W   = CREDIT_W + 3;
  localparam logic [SUM_W-1:0]  PRICE_S = SUM_W'(PRICE_NK);
  localparam logic [SUM_W-1:0]  MAX_S   = SUM_W'(MAX_CREDIT_NK);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_VEND,
    S_CHANGE,
    S_REFUND
  } state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [STOCK_W-1:0]  stock_q, stock_d;
  logic                sold_q, sold_d;
  logic                busy_q, busy_d;

  logic [2:0]          coin_val;
  logic                coin_any;
  logic                coin_multi;
  logic [SUM_W-1:0]    sum;
  logic                open_for_coins;
  logic                cancel_hit;
  logic                reject;
  logic                paying;
  logic                chg_dime;
  logic                chg_nickle;

  // Coin decode; value is meaningless when more than one input is high,
  // but that case is always rejected.
  always_comb begin
    coin_val = '0;
    if (i_quarter)     coin_val = 3'd5;
    else if (i_dime)   coin_val = 3'd2;
    else if (i_nickle) coin_val = 3'd1;
  end

  assign coin_any   = i_nickle | i_dime | i_quarter;
  assign coin_multi = (i_nickle & i_dime) | (i_nickle & i_quarter) | (i_dime & i_quarter);
  assign sum        = SUM_W'(credit_q) + SUM_W'(coin_val);

  assign open_for_coins = (state_q == S_IDLE) || (state_q == S_COLLECT);
  assign cancel_hit     = (state_q == S_COLLECT) && i_cancel;

  // A cancel in the same cycle as a coin takes priority, so the coin bounces.
  assign reject = coin_any &&
                  (coin_multi || !open_for_coins || cancel_hit || sold_q || (sum > MAX_S));

  assign paying     = (state_q == S_CHANGE) || (state_q == S_REFUND);
  assign chg_dime   = paying && i_chg_ready && (credit_q >= CREDIT_W'(2));
  assign chg_nickle = paying && i_chg_ready && (credit_q == CREDIT_W'(1));

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (cancel_hit) begin
          state_d = S_REFUND;
        end else if (coin_any && !reject) begin
          if (sum >= PRICE_S) begin
            credit_d = CREDIT_W'(sum - PRICE_S);
            state_d  = S_VEND;
          end else begin
            credit_d = CREDIT_W'(sum);
            state_d  = S_COLLECT;
          end
        end
      end
      S_VEND: begin
        state_d = (credit_q != '0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE, S_REFUND: begin
        if (chg_dime) begin
          credit_d = credit_q - CREDIT_W'(2);
        end else if (chg_nickle) begin
          credit_d = credit_q - CREDIT_W'(1);
        end
        if (credit_d == '0) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
      end
    endcase
  end

  // Stock never wraps: the VEND decrement is guarded even though coins are
  // already refused while sold out.
  always_comb begin
    stock_d = stock_q;
    if ((state_q == S_IDLE) && i_restock) begin
      stock_d = STOCK_W'(INIT_STOCK);
    end else if ((state_q == S_VEND) && (stock_q != '0)) begin
      stock_d = stock_q - STOCK_W'(1);
    end
  end

  assign sold_d = (stock_d == '0);
  assign busy_d = (state_d == S_VEND) || (state_d == S_CHANGE) || (state_d == S_REFUND);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      stock_q  <= STOCK_W'(INIT_STOCK);
      sold_q   <= (INIT_STOCK == 0);
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      stock_q  <= stock_d;
      sold_q   <= sold_d;
      busy_q   <= busy_d;
    end
  end

  assign o_soda        = (state_q == S_VEND);
  assign o_chg_dime    = chg_dime;
  assign o_chg_nickle  = chg_nickle;
  assign o_coin_reject = reject;
  assign o_credit      = credit_q;
  assign o_stock       = stock_q;
  assign o_sold_out    = sold_q;
  assign o_busy        = busy_q;

endmodule
